branch_cond_unit: RTL and testbench

BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

---
 rtl/branch_cond_pkg.sv | 22 ++
 rtl/branch_cond_unit_cond_eval.sv | 34 +++
 rtl/branch_cond_unit.sv | 113 +++++++++++
 tb/tb_branch_cond_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_cond_pkg.sv
// Shared encodings for the branch condition unit:
// condition codes and FSM state.
package branch_cond_pkg;

   typedef enum logic [2:0] {
      COND_ZR = 3'b000,
      COND_NZ = 3'b001,
      COND_PL = 3'b010,
      COND_MI = 3'b011,
      COND_AL = 3'b100,
      COND_NV = 3'b101,
      COND_GT = 3'b110,
      COND_LE = 3'b111
   } cond_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EVAL = 2'b01,
      ST_HOLD = 2'b10
   } state_e;

endpackage

// File: rtl/branch_cond_unit_cond_eval.sv
// Combinational branch condition evaluator on a
// two's complement operand.
module cond_eval
   import branch_cond_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] operand,
   input  logic [2:0]        Cond,
   output logic              taken
);

   logic zero;
   logic neg;

   assign zero = (operand == '0);
   assign neg  = operand[DATA_W-1];

   always_comb begin
      taken = 1'b0;
      case (cond_e'(Cond))
         COND_ZR: taken = zero;
         COND_NZ: taken = ~zero;
         COND_PL: taken = ~neg;
         COND_MI: taken = neg;
         COND_AL: taken = 1'b1;
         COND_NV: taken = 1'b0;
         COND_GT: taken = ~neg & ~zero;
         COND_LE: taken = neg | zero;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_cond_unit.sv
// Branch condition unit: operand stage, IDLE/EVAL/HOLD
// handshake FSM and saturating taken/not-taken counters.
module branch_cond_unit
   import branch_cond_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 8
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              CONin,
   input  logic [2:0]        Cond,
   input  logic [DATA_W-1:0] Bus,
   input  logic              BranchAck,
   input  logic              CntClr,
   output logic              BranchValid,
   output logic              BranchOut,
   output logic              Busy,
   output logic              Overrun,
   output logic [CNT_W-1:0]  TakenCnt,
   output logic [CNT_W-1:0]  NotTakenCnt
);

   state_e             state_q, state_d;
   logic [DATA_W-1:0]  op_q;
   logic [2:0]         cond_q;
   logic               valid_q, out_q, ovr_q;
   logic [CNT_W-1:0]   tcnt_q, ncnt_q;
   logic               taken;
   logic               in_idle, in_eval, in_hold;
   logic               accept, drop;

   assign in_idle = (state_q == ST_IDLE);
   assign in_eval = (state_q == ST_EVAL);
   assign in_hold = (state_q == ST_HOLD);

   // HOLD with ack and a new request chains straight into EVAL
   assign accept = CONin & (in_idle | (in_hold & BranchAck));
   assign drop   = CONin & (in_eval | (in_hold & ~BranchAck));

   cond_eval #(
      .DATA_W (DATA_W)
   ) u_eval (
      .operand (op_q),
      .Cond    (cond_q),
      .taken   (taken)
   );

   always_ff @(posedge Clock) begin
      if (!Resetn) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (CONin) state_d = ST_EVAL;
         ST_EVAL: state_d = ST_HOLD;
         ST_HOLD: begin
            if (BranchAck) state_d = CONin ? ST_EVAL : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      Busy = in_eval | in_hold;
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         op_q   <= '0;
         cond_q <= '0;
      end else if (accept) begin
         op_q   <= Bus;
         cond_q <= Cond;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         valid_q <= 1'b0;
         out_q   <= 1'b0;
      end else if (in_eval) begin
         valid_q <= 1'b1;
         out_q   <= taken;
      end else if (in_hold && BranchAck) begin
         valid_q <= 1'b0;
         out_q   <= 1'b0;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn || CntClr) begin
         tcnt_q <= '0;
         ncnt_q <= '0;
         ovr_q  <= 1'b0;
      end else begin
         if (drop) ovr_q <= 1'b1;
         if (in_eval && taken && tcnt_q != '1)
            tcnt_q <= tcnt_q + CNT_W'(1);
         if (in_eval && !taken && ncnt_q != '1)
            ncnt_q <= ncnt_q + CNT_W'(1);
      end
   end

   assign BranchValid = valid_q;
   assign BranchOut   = out_q;
   assign Overrun     = ovr_q;
   assign TakenCnt    = tcnt_q;
   assign NotTakenCnt = ncnt_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Random and directed checks of branch_cond_unit against a
// behavioural request/response model (two counter widths).
module tb_branch_cond_unit;

   logic        clk;
   logic        rstn, con, ack, clr;
   logic [2:0]  cond;
   logic [31:0] bus;

   logic       v8, o8, b8, r8;
   logic [7:0] t8, n8;
   logic       v2, o2, b2, r2;
   logic [1:0] t2, n2;

   int errs;
   int checks;

   // model: phase 0 = no request, 1 = evaluating, 2 = result held
   int          m_ph;
   logic [31:0] m_op;
   logic [2:0]  m_cond;
   int          m_val, m_out, m_ovr, m_t, m_n;

   branch_cond_unit #(.DATA_W(32), .CNT_W(8)) dut (
      .Clock(clk), .Resetn(rstn), .CONin(con), .Cond(cond),
      .Bus(bus), .BranchAck(ack), .CntClr(clr),
      .BranchValid(v8), .BranchOut(o8), .Busy(b8),
      .Overrun(r8), .TakenCnt(t8), .NotTakenCnt(n8)
   );

   branch_cond_unit #(.DATA_W(32), .CNT_W(2)) dut_s (
      .Clock(clk), .Resetn(rstn), .CONin(con), .Cond(cond),
      .Bus(bus), .BranchAck(ack), .CntClr(clr),
      .BranchValid(v2), .BranchOut(o2), .Busy(b2),
      .Overrun(r2), .TakenCnt(t2), .NotTakenCnt(n2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int ref_taken(logic [31:0] op,
                                    logic [2:0] c);
      int s;
      s = $signed(op);
      case (c)
         3'd0: return int'(s == 0);
         3'd1: return int'(s != 0);
         3'd2: return int'(s >= 0);
         3'd3: return int'(s < 0);
         3'd4: return 1;
         3'd5: return 0;
         3'd6: return int'(s > 0);
         default: return int'(s <= 0);
      endcase
   endfunction

   function automatic int sat(int v, int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_edge();
      int r;
      if (!rstn) begin
         m_ph = 0; m_op = '0; m_cond = '0;
         m_val = 0; m_out = 0; m_ovr = 0; m_t = 0; m_n = 0;
         return;
      end
      case (m_ph)
         0: if (con) begin
            m_op = bus; m_cond = cond; m_ph = 1;
         end
         1: begin
            r = ref_taken(m_op, m_cond);
            m_val = 1; m_out = r;
            if (r != 0) m_t++; else m_n++;
            if (con) m_ovr = 1;
            m_ph = 2;
         end
         default: begin
            if (ack) begin
               m_val = 0; m_out = 0;
               if (con) begin
                  m_op = bus; m_cond = cond; m_ph = 1;
               end else m_ph = 0;
            end else if (con) m_ovr = 1;
         end
      endcase
      if (clr) begin
         m_t = 0; m_n = 0; m_ovr = 0;
      end
   endtask

   task automatic step(input logic i_rst, input logic i_con,
                       input logic [2:0] i_cond,
                       input logic [31:0] i_bus,
                       input logic i_ack, input logic i_clr);
      rstn = i_rst; con = i_con; cond = i_cond;
      bus = i_bus; ack = i_ack; clr = i_clr;
      @(posedge clk);
      model_edge();
      #1;
      chk("valid", 32'(v8), 32'(m_val));
      chk("out", 32'(o8), 32'(m_out));
      chk("busy", 32'(b8), 32'(m_ph != 0));
      chk("ovr", 32'(r8), 32'(m_ovr));
      chk("tcnt", 32'(t8), 32'(sat(m_t, 255)));
      chk("ncnt", 32'(n8), 32'(sat(m_n, 255)));
      chk("tcnt_s", 32'(t2), 32'(sat(m_t, 3)));
      chk("ncnt_s", 32'(n2), 32'(sat(m_n, 3)));
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
   endtask

   task automatic ackc();
      step(1'b1, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
   endtask

   // request, wait two edges, check result, acknowledge
   task automatic req(input string tag, input logic [2:0] c,
                      input logic [31:0] b, input logic exp);
      step(1'b1, 1'b1, c, b, 1'b0, 1'b0);
      idle();
      idle();
      chk(tag, 32'(o8), 32'(exp));
      ackc();
   endtask

   initial begin
      logic [31:0] pick [5];
      logic        held;
      errs = 0; checks = 0;
      m_ph = 0; m_op = '0; m_cond = '0;
      m_val = 0; m_out = 0; m_ovr = 0; m_t = 0; m_n = 0;
      rstn = 1'b0; con = 1'b0; cond = '0;
      bus = '0; ack = 1'b0; clr = 1'b0;

      step(1'b0, 1'b1, 3'd4, 32'd5, 1'b1, 1'b0);
      step(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
      chk("rst_valid", 32'(v8), 32'd0);
      chk("rst_busy", 32'(b8), 32'd0);

      // latency: request at edge 0, result held after edge 2
      step(1'b1, 1'b1, 3'd0, 32'd0, 1'b0, 1'b0);
      chk("lat_e0_busy", 32'(b8), 32'd1);
      chk("lat_e0_valid", 32'(v8), 32'd0);
      idle();
      idle();
      chk("lat_valid", 32'(v8), 32'd1);
      chk("lat_out", 32'(o8), 32'd1);
      chk("lat_tcnt", 32'(t8), 32'd1);
      ackc();
      chk("ack_valid", 32'(v8), 32'd0);

      req("mi_neg", 3'd3, 32'h8000_0000, 1'b1);
      req("pl_neg", 3'd2, 32'h8000_0000, 1'b0);
      req("gt_zero", 3'd6, 32'h0, 1'b0);
      req("le_zero", 3'd7, 32'h0, 1'b1);
      req("nz_one", 3'd1, 32'h1, 1'b1);
      req("nv", 3'd5, 32'h0, 1'b0);

      // hold stable, then back-to-back accept
      step(1'b1, 1'b1, 3'd1, 32'h7, 1'b0, 1'b0);
      idle();
      held = o8;
      for (int i = 0; i < 5; i++) begin
         idle();
         chk("hold_valid", 32'(v8), 32'd1);
         chk("hold_out", 32'(o8), 32'(held));
      end
      step(1'b1, 1'b1, 3'd4, 32'h0, 1'b1, 1'b0);
      chk("b2b_busy", 32'(b8), 32'd1);
      chk("b2b_valid", 32'(v8), 32'd0);
      idle();
      idle();
      chk("b2b_out", 32'(o8), 32'd1);
      chk("b2b_ovr", 32'(r8), 32'd0);
      ackc();

      // overrun: request during EVAL is dropped
      step(1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 3'd4, 32'd0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 3'd5, 32'd0, 1'b0, 1'b0);
      idle();
      chk("ovr_set", 32'(r8), 32'd1);
      chk("ovr_tcnt", 32'(t8), 32'd1);
      chk("ovr_ncnt", 32'(n8), 32'd0);
      ackc();
      idle();
      chk("ovr_idle", 32'(b8), 32'd0);
      step(1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
      chk("clr_ovr", 32'(r8), 32'd0);
      chk("clr_tcnt", 32'(t8), 32'd0);

      // saturation on the 2-bit instance
      for (int i = 0; i < 5; i++) req("sat_req", 3'd4, 32'd9, 1'b1);
      chk("sat_t2", 32'(t2), 32'd3);
      chk("sat_t8", 32'(t8), 32'd5);
      step(1'b1, 1'b1, 3'd4, 32'd0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
      chk("clr_pri_t2", 32'(t2), 32'd0);
      chk("clr_pri_t8", 32'(t8), 32'd0);
      chk("clr_keep_valid", 32'(v8), 32'd1);
      ackc();

      // reset while holding a result
      step(1'b1, 1'b1, 3'd4, 32'd0, 1'b0, 1'b0);
      idle();
      step(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
      chk("mid_rst_valid", 32'(v8), 32'd0);
      chk("mid_rst_tcnt", 32'(t8), 32'd0);
      req("post_rst", 3'd0, 32'd0, 1'b1);
      chk("post_rst_tcnt", 32'(t8), 32'd1);

      pick[0] = 32'h0;
      pick[1] = 32'h8000_0000;
      pick[2] = 32'h1;
      pick[3] = 32'hffff_ffff;
      for (int i = 0; i < 400; i++) begin
         pick[4] = $urandom;
         step(($urandom % 50) != 0, ($urandom % 3) == 0,
              3'($urandom), pick[$urandom % 5],
              ($urandom % 2) == 0, ($urandom % 40) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
